// File: rtl/acc_mac_engine.sv
// Element-wise multiply and dot-product engine.
// A single 8x8 multiplier is time-shared across all operand pairs through a two-stage
// pipeline: stage 1 registers one product per cycle, stage 2 writes it back and accumulates.
module acc_mac_engine #(
  parameter int unsigned N_ELEM    = 9,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SUM_WIDTH = 20
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          start,
  input  logic [N_ELEM*IN_WIDTH-1:0]    acc_in_A,
  input  logic [N_ELEM*IN_WIDTH-1:0]    acc_in_B,
  output logic                          busy,
  output logic                          done,
  output logic [N_ELEM*OUT_WIDTH-1:0]   acc_out,
  output logic [SUM_WIDTH-1:0]          acc_sum
);

  localparam int unsigned IdxW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_ELEM - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDrain} state_e;

  state_e state_q, state_d;

  logic [N_ELEM*IN_WIDTH-1:0] a_q, b_q;
  logic [IdxW-1:0]            idx_q;
  logic [OUT_WIDTH-1:0]       p1_q;
  logic [IdxW-1:0]            i1_q;
  logic                       v1_q;

  logic                 accept;
  logic                 issue;
  logic                 drain;
  logic [IN_WIDTH-1:0]  a_sel, b_sel;
  logic [OUT_WIDTH-1:0] mul;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    drain   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        issue = 1'b1;
        if (idx_q == LastIdx) state_d = StDrain;
      end
      StDrain: begin
        drain   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shared multiplier operating on the snapshotted operands.
  always_comb begin
    a_sel = a_q[idx_q*IN_WIDTH +: IN_WIDTH];
    b_sel = b_q[idx_q*IN_WIDTH +: IN_WIDTH];
    mul   = OUT_WIDTH'(a_sel) * OUT_WIDTH'(b_sel);
  end

  // FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand snapshot, issue index, stage-1 product register and handshake flags.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      p1_q  <= '0;
      i1_q  <= '0;
      v1_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      v1_q <= issue;
      done <= drain;
      if (accept) begin
        a_q   <= acc_in_A;
        b_q   <= acc_in_B;
        idx_q <= '0;
        busy  <= 1'b1;
      end
      if (issue) begin
        p1_q  <= mul;
        i1_q  <= idx_q;
        idx_q <= idx_q + 1'b1;
      end
      if (drain) busy <= 1'b0;
    end
  end

  // Stage 2: write back each product and accumulate the dot product.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      acc_out <= '0;
      acc_sum <= '0;
    end else if (accept) begin
      acc_out <= '0;
      acc_sum <= '0;
    end else if (v1_q) begin
      acc_out[i1_q*OUT_WIDTH +: OUT_WIDTH] <= p1_q;
      acc_sum <= acc_sum + SUM_WIDTH'(p1_q);
    end
  end

endmodule

// File: tb/tb_acc_mac_engine.sv
// Directed plus randomized bench for acc_mac_engine with a plain-arithmetic reference model.
module tb_acc_mac_engine;

  localparam int unsigned NE = 9;

  logic          HCLK;
  logic          HRESET;
  logic          start;
  logic [71:0]   acc_in_A;
  logic [71:0]   acc_in_B;
  logic          busy;
  logic          done;
  logic [143:0]  acc_out;
  logic [19:0]   acc_sum;

  int checks   = 0;
  int failures = 0;

  acc_mac_engine dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .start    (start),
    .acc_in_A (acc_in_A),
    .acc_in_B (acc_in_B),
    .busy     (busy),
    .done     (done),
    .acc_out  (acc_out),
    .acc_sum  (acc_sum)
  );

  // Clock starts late so reset can be observed with no edges.
  initial begin
    HCLK = 1'b0;
    #20;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: element-wise products and their sum, computed element by element.
  task automatic model(input logic [71:0] a, input logic [71:0] b,
                       output logic [143:0] o, output logic [19:0] s);
    int unsigned sum;
    int unsigned ai, bi;
    o   = '0;
    sum = 0;
    for (int i = 0; i < NE; i++) begin
      ai = int'(a[i*8 +: 8]);
      bi = int'(b[i*8 +: 8]);
      o[i*16 +: 16] = 16'(ai * bi);
      sum += ai * bi;
    end
    s = 20'(sum);
  endtask

  function automatic logic [71:0] fill(input logic [7:0] v);
    logic [71:0] r;
    for (int i = 0; i < NE; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [71:0] rand72();
    logic [71:0] r;
    for (int i = 0; i < NE; i++) r[i*8 +: 8] = 8'($urandom_range(255));
    return r;
  endfunction

  // Full run with latency, busy-length, result and hold checks.
  task automatic run_check(input logic [71:0] a, input logic [71:0] b, input string tag);
    logic [143:0] eo;
    logic [19:0]  es;
    int n;
    int busy_cnt;
    model(a, b, eo, es);
    @(negedge HCLK);
    acc_in_A = a;
    acc_in_B = b;
    start    = 1'b1;
    @(negedge HCLK);
    start    = 1'b0;
    acc_in_A = rand72();
    acc_in_B = rand72();
    n        = 1;
    busy_cnt = 0;
    while (!done && n < 30) begin
      if (busy) busy_cnt++;
      @(negedge HCLK);
      n++;
    end
    chk({tag, "_latency"}, 144'(n), 144'(11));
    chk({tag, "_busy_cycles"}, 144'(busy_cnt), 144'(10));
    chk({tag, "_out"}, acc_out, eo);
    chk({tag, "_sum"}, 144'(acc_sum), 144'(es));
    @(negedge HCLK);
    chk({tag, "_done_cleared"}, 144'({busy, done}), 144'(0));
    chk({tag, "_sum_held"}, 144'(acc_sum), 144'(es));
  endtask

  initial begin
    logic [143:0] eo;
    logic [19:0]  es;
    int n;
    int done_cnt;
    int t1;
    int t2;
    logic [19:0] s1;
    logic [19:0] s2;

    start    = 1'b0;
    acc_in_A = '0;
    acc_in_B = '0;
    HRESET   = 1'b1;
    #2;
    chk("reset_busy", 144'(busy), 144'(0));
    chk("reset_done", 144'(done), 144'(0));
    chk("reset_out", acc_out, 144'(0));
    chk("reset_sum", 144'(acc_sum), 144'(0));
    @(negedge HCLK);
    HRESET = 1'b0;

    // Basic: A = 1..9, B = 2.
    begin
      logic [71:0] a;
      for (int i = 0; i < NE; i++) a[i*8 +: 8] = 8'(i + 1);
      model(a, fill(8'd2), eo, es);
      chk("basic_model_sum", 144'(es), 144'(90));
      run_check(a, fill(8'd2), "basic");
    end

    run_check(fill(8'hFF), fill(8'hFF), "max");
    chk("max_sum_const", 144'(acc_sum), 144'(20'h8EE09));
    chk("max_elem0", 144'(acc_out[15:0]), 144'(16'hFE01));

    for (int r = 0; r < 4; r++) run_check(rand72(), rand72(), "rand");

    // Snapshot and start-while-busy ignored.
    @(negedge HCLK);
    acc_in_A = fill(8'd3);
    acc_in_B = fill(8'd4);
    start    = 1'b1;
    done_cnt = 0;
    s1       = '0;
    for (n = 1; n <= 30; n++) begin
      @(negedge HCLK);
      start = 1'b0;
      if (n == 3) begin
        acc_in_A = '0;
        start    = 1'b1;
      end
      if (done) begin
        done_cnt++;
        s1 = acc_sum;
        if (done_cnt == 1) chk("snap_out", acc_out, {NE{16'd12}});
      end
    end
    chk("snap_done_count", 144'(done_cnt), 144'(1));
    chk("snap_sum", 144'(s1), 144'(108));

    // Reset mid-run.
    @(negedge HCLK);
    acc_in_A = fill(8'd7);
    acc_in_B = fill(8'd9);
    start    = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (5) @(negedge HCLK);
    chk("midrst_partial_nonzero", 144'(acc_sum != 0), 144'(1));
    HRESET = 1'b1;
    #1;
    chk("midrst_out", acc_out, 144'(0));
    chk("midrst_sum", 144'(acc_sum), 144'(0));
    chk("midrst_busy_done", 144'({busy, done}), 144'(0));
    repeat (2) @(negedge HCLK);
    HRESET   = 1'b0;
    done_cnt = 0;
    repeat (15) begin
      @(negedge HCLK);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 144'(done_cnt), 144'(0));
    run_check(fill(8'd1), fill(8'd1), "post_rst");

    // Back-to-back with start held high.
    @(negedge HCLK);
    acc_in_A = fill(8'd1);
    acc_in_B = fill(8'd1);
    start    = 1'b1;
    done_cnt = 0;
    t1 = 0;
    t2 = 0;
    s1 = '0;
    s2 = '0;
    for (n = 1; n <= 40; n++) begin
      @(negedge HCLK);
      if (n == 1) acc_in_B = fill(8'd5);
      if (n == 12) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin t1 = n; s1 = acc_sum; end
        if (done_cnt == 2) begin t2 = n; s2 = acc_sum; end
      end
    end
    chk("b2b_done_count", 144'(done_cnt), 144'(2));
    chk("b2b_first_at", 144'(t1), 144'(11));
    chk("b2b_spacing", 144'(t2 - t1), 144'(11));
    chk("b2b_sum1", 144'(s1), 144'(9));
    chk("b2b_sum2", 144'(s2), 144'(45));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_mac_engine.md
Name: acc_mac_engine

Overview:
- Compute core that sits directly downstream of the accelerator's APB register wrapper.
- Consumes the wrapper's nine 8-bit A operands and nine 8-bit B operands.
- Produces nine 16-bit element-wise products plus their dot-product sum.
- Uses a single time-shared 8x8 multiplier in a two-stage pipeline, sequenced by a start/busy/done handshake driven from the wrapper.

Parameters:
- N_ELEM, 9, number of operand pairs processed per run.
- IN_WIDTH, 8, unsigned operand width.
- OUT_WIDTH, 16, product width; must equal 2*IN_WIDTH.
- SUM_WIDTH, 20, accumulator width; must be >= OUT_WIDTH + clog2(N_ELEM).

Ports:
- HCLK  in  1  single clock, rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled on the rising edge.
- acc_in_A  in  N_ELEM*IN_WIDTH  operand A vector; element i at bits [i*IN_WIDTH +: IN_WIDTH].
- acc_in_B  in  N_ELEM*IN_WIDTH  operand B vector; same packing as A.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle completion pulse.
- acc_out  out  N_ELEM*OUT_WIDTH  products; element i at [i*OUT_WIDTH +: OUT_WIDTH].
- acc_sum  out  SUM_WIDTH  sum of all products of the last run.

Behaviour:
- Interface (already decided): one clock, HCLK; reset HRESET is asynchronous and active-high.
- Reset: state IDLE; busy=0, done=0, acc_out=0, acc_sum=0; index and pipeline valid bits cleared. Reset takes effect immediately, including mid-run. No partial results survive.
- Arithmetic: all arithmetic is unsigned. Product = A[i]*B[i], full 16 bits, never truncated. The sum cannot overflow at default widths (max 585225 < 2^20).
- States:
  - IDLE: busy=0. If start=1 at an edge, then on that edge: snapshot acc_in_A/acc_in_B into internal registers, clear acc_out and acc_sum, set idx=0, busy=1, go to MAC.
  - MAC: each edge issues element idx into stage 1 (registered product p1, tag i1, valid v1) and increments idx. After issuing idx=N_ELEM-1, go to DRAIN.
  - Stage 2 (runs every edge when v1=1): acc_out[i1] <= p1; acc_sum <= acc_sum + p1.
  - DRAIN: stage 2 retires the last product. On this edge busy<=0, done<=1, go to IDLE.
  - done is cleared on the following edge unless a new run completes then (impossible, N_ELEM>=1).
- Latency: if start is sampled at edge E0, issues occur at E1..E9 and retires at E2..E10. busy=1 after E0 through E10. done=1 for exactly the cycle following E10, i.e. N_ELEM+1 edges after E0. acc_out/acc_sum are final and stable while done=1 and remain held until the next accepted start.
- start while busy=1 is ignored; no queuing.
- start high during the done cycle (state IDLE) is accepted: back-to-back runs, no dead cycle.
- start held high continuously: a new run starts every N_ELEM+2 edges.
- Input changes on acc_in_A/B after E0 do not affect the current run; the snapshot is used.
- Intermediate acc_out/acc_sum values are visible during a run. They are valid only when done=1 or busy=0 after a completed run.
- No error conditions; outputs are purely register-driven, with no combinational path from inputs to outputs.

Test Plan:
- Reset: assert HRESET with no clock running -> busy=0, done=0, acc_out=0, acc_sum=0 immediately.
- Basic run: A=1..9, B=all 2, start pulse at E0 -> done high for exactly the cycle after E10; acc_out = 2,4,6,...,18; acc_sum = 90; busy high for 10 cycles.
- Max values: A=B=all 255 -> every acc_out element = 0xFE01 (65025); acc_sum = 0x8EE09 (585225); no truncation.
- Snapshot/ignore: A=all 3, B=all 4, start; on E3 change A to all 0 and pulse start -> results still all 12 with sum 108; only one done pulse; no second run.
- Reset mid-run: start, then assert HRESET after E5 -> outputs zero immediately, done never pulses. After release, a new start with A=B=all 1 yields sum 9 at the expected edge.
- Back-to-back: hold start high for two runs (A=all 1, B=all 1, then B changed to all 5 before the second accept) -> done pulses 11 edges apart; sums are 9 then 45.
